// File: rtl/ppu_ctrl_pkg.sv
// Shared definitions for the PPU XIN sequencer: FSM state encoding and default reset hold.
package ppu_ctrl_pkg;

  typedef logic [1:0] ppu_state_t;

  localparam ppu_state_t StIdle = 2'd0;
  localparam ppu_state_t StRun  = 2'd1;
  localparam ppu_state_t StStep = 2'd2;
  localparam ppu_state_t StSeq  = 2'd3;

  localparam int unsigned DefaultResetHold = 16;

endpackage

// File: rtl/ppu_xin_divider.sv
// XIN generator: latched half-period divider, toggle strobe, XIN flop and registered rise strobe.
module ppu_xin_divider #(
  parameter int unsigned DIV_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic                 halt_i,
  input  logic                 enable_i,
  input  logic                 set_hi_i,
  input  logic                 set_lo_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 xin_o,
  output logic                 xin_rise_o,
  output logic                 toggle_o
);

  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic                 xin_q, xin_d;
  logic                 rise_q, rise_d;

  // Toggle fires when the counter has spanned div+1 cycles since entry or the last toggle.
  assign toggle_o = enable_i && (cnt_q == div_q);

  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    xin_d = xin_q;
    if (load_i) begin
      div_d = div_i;
      cnt_d = '0;
      xin_d = 1'b0;
    end else if (halt_i) begin
      cnt_d = '0;
      xin_d = 1'b0;
    end else if (enable_i) begin
      if (toggle_o) begin
        cnt_d = '0;
        xin_d = ~xin_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (set_hi_i && !set_lo_i) begin
      xin_d = 1'b1;
    end else if (set_lo_i && !set_hi_i) begin
      xin_d = 1'b0;
    end
    rise_d = xin_d & ~xin_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      div_q  <= '0;
      cnt_q  <= '0;
      xin_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      xin_q  <= xin_d;
      rise_q <= rise_d;
    end
  end

  assign xin_o      = xin_q;
  assign xin_rise_o = rise_q;

endmodule

// File: rtl/ppu_xin_sequencer.sv
// PPU XIN/reset sequencer: manual XIN, free-run, N-edge step and hardware reset sequence.
// Optional XIN rising-edge counter enabled by defining PPU_XIN_EDGE_COUNTER_EN.
module ppu_xin_sequencer
  import ppu_ctrl_pkg::*;
#(
  parameter int unsigned NUM_RESETS = 2,
  parameter int unsigned DIV_WIDTH  = 8,
  parameter int unsigned STEP_WIDTH = 8,
  parameter int unsigned RESET_HOLD = DefaultResetHold
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  xin_lo_i,
  input  logic                  xin_hi_i,
  input  logic [NUM_RESETS-1:0] set_ppu_reset_i,
  input  logic [NUM_RESETS-1:0] clr_ppu_reset_i,
  input  logic [DIV_WIDTH-1:0]  div_i,
  input  logic [STEP_WIDTH-1:0] step_count_i,
  input  logic                  run_i,
  input  logic                  stop_i,
  input  logic                  step_i,
  input  logic                  start_seq_i,
  output logic                  xin,
  output logic [NUM_RESETS-1:0] ppu_reset_n,
  output logic                  xin_rise_o,
  output logic                  busy_o,
  output logic [31:0]           xin_edges_o
);

  localparam int unsigned HoldW = $clog2(RESET_HOLD + 1);
  localparam int unsigned CntW  = (STEP_WIDTH > HoldW) ? STEP_WIDTH : HoldW;
  localparam logic [CntW-1:0] HoldCnt = CntW'(RESET_HOLD);

  ppu_state_t            state_q, state_d;
  logic [CntW-1:0]       edge_cnt_q, edge_cnt_d;
  logic [STEP_WIDTH-1:0] target_q, target_d;
  logic [NUM_RESETS-1:0] rst_n_q, rst_n_d;
  logic                  busy_q;
  logic                  busy;
  logic                  seq_enter;

  logic div_load, div_halt, div_enable, man_hi, man_lo, toggle;

  ppu_xin_divider #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_divider (
    .clock      (clock),
    .reset      (reset),
    .load_i     (div_load),
    .halt_i     (div_halt),
    .enable_i   (div_enable),
    .set_hi_i   (man_hi),
    .set_lo_i   (man_lo),
    .div_i      (div_i),
    .xin_o      (xin),
    .xin_rise_o (xin_rise_o),
    .toggle_o   (toggle)
  );

  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    target_d   = target_q;
    rst_n_d    = rst_n_q;
    div_load   = 1'b0;
    div_halt   = 1'b0;
    man_hi     = 1'b0;
    man_lo     = 1'b0;
    seq_enter  = 1'b0;
    div_enable = (state_q != StIdle);
    busy       = (state_q == StStep) || (state_q == StSeq);

    if (stop_i) begin
      state_d    = StIdle;
      div_halt   = 1'b1;
      edge_cnt_d = '0;
    end else if (!busy && start_seq_i) begin
      state_d    = StSeq;
      div_load   = 1'b1;
      edge_cnt_d = '0;
      seq_enter  = 1'b1;
      rst_n_d    = '0;
    end else if (!busy && run_i) begin
      state_d    = StRun;
      div_load   = 1'b1;
      edge_cnt_d = '0;
    end else if (!busy && step_i) begin
      edge_cnt_d = '0;
      if (step_count_i != '0) begin
        state_d  = StStep;
        div_load = 1'b1;
        target_d = step_count_i;
      end else begin
        state_d  = StIdle;
        div_halt = 1'b1;
      end
    end else begin
      case (state_q)
        StIdle: begin
          man_hi = xin_hi_i;
          man_lo = xin_lo_i;
        end
        StStep: begin
          // Rising toggles are counted; the falling toggle after the last rise ends the step.
          if (toggle) begin
            if (!xin) begin
              edge_cnt_d = edge_cnt_q + 1'b1;
            end else if (edge_cnt_q == CntW'(target_q)) begin
              state_d    = StIdle;
              div_halt   = 1'b1;
              edge_cnt_d = '0;
            end
          end
        end
        StSeq: begin
          // Release coincides with the falling toggle; XIN keeps running into RUN.
          if (toggle) begin
            if (!xin) begin
              edge_cnt_d = edge_cnt_q + 1'b1;
            end else if (edge_cnt_q == HoldCnt) begin
              state_d    = StRun;
              rst_n_d    = '1;
              edge_cnt_d = '0;
            end
          end
        end
        default: ;
      endcase
    end

    if ((state_q != StSeq) && !seq_enter) begin
      for (int i = 0; i < NUM_RESETS; i++) begin
        if (set_ppu_reset_i[i] && !clr_ppu_reset_i[i]) begin
          rst_n_d[i] = 1'b0;
        end else if (clr_ppu_reset_i[i] && !set_ppu_reset_i[i]) begin
          rst_n_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= StIdle;
      edge_cnt_q <= '0;
      target_q   <= '0;
      rst_n_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      target_q   <= target_d;
      rst_n_q    <= rst_n_d;
      busy_q     <= (state_d == StStep) || (state_d == StSeq);
    end
  end

  assign ppu_reset_n = rst_n_q;
  assign busy_o      = busy_q;

`ifdef PPU_XIN_EDGE_COUNTER_EN
  logic [31:0] edges_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      edges_q <= '0;
    end else if (xin_rise_o) begin
      edges_q <= edges_q + 32'd1;
    end
  end

  assign xin_edges_o = edges_q;
`else
  assign xin_edges_o = '0;
`endif

endmodule

// File: tb/tb_ppu_xin_sequencer.sv
// Self-checking bench for ppu_xin_sequencer using a closed-form XIN timing model.
module tb_ppu_xin_sequencer;

  localparam int NR   = 2;
  localparam int DW   = 8;
  localparam int SW   = 8;
  localparam int HOLD = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          xin_lo_i = 1'b0;
  logic          xin_hi_i = 1'b0;
  logic [NR-1:0] set_ppu_reset_i = '0;
  logic [NR-1:0] clr_ppu_reset_i = '0;
  logic [DW-1:0] div_i = '0;
  logic [SW-1:0] step_count_i = '0;
  logic          run_i = 1'b0;
  logic          stop_i = 1'b0;
  logic          step_i = 1'b0;
  logic          start_seq_i = 1'b0;
  logic          xin;
  logic [NR-1:0] ppu_reset_n;
  logic          xin_rise_o;
  logic          busy_o;
  logic [31:0]   xin_edges_o;

  int total = 0;
  int bad   = 0;
  logic [NR-1:0] exp_rst;

  ppu_xin_sequencer #(
    .NUM_RESETS (NR),
    .DIV_WIDTH  (DW),
    .STEP_WIDTH (SW),
    .RESET_HOLD (HOLD)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .xin_lo_i        (xin_lo_i),
    .xin_hi_i        (xin_hi_i),
    .set_ppu_reset_i (set_ppu_reset_i),
    .clr_ppu_reset_i (clr_ppu_reset_i),
    .div_i           (div_i),
    .step_count_i    (step_count_i),
    .run_i           (run_i),
    .stop_i          (stop_i),
    .step_i          (step_i),
    .start_seq_i     (start_seq_i),
    .xin             (xin),
    .ppu_reset_n     (ppu_reset_n),
    .xin_rise_o      (xin_rise_o),
    .busy_o          (busy_o),
    .xin_edges_o     (xin_edges_o)
  );

  always #5 clock = ~clock;

  // XIN level j edges after entry: toggles every d+1 edges starting low.
  function automatic logic exp_xin(input int j, input int d);
    return ((j / (d + 1)) % 2) == 1;
  endfunction

  function automatic logic exp_rise(input int j, input int d);
    return (j > 0) && ((j % (d + 1)) == 0) && exp_xin(j, d);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_chan(input logic [NR-1:0] s, input logic [NR-1:0] c);
    for (int i = 0; i < NR; i++) begin
      if (s[i] && !c[i]) exp_rst[i] = 1'b0;
      else if (c[i] && !s[i]) exp_rst[i] = 1'b1;
    end
  endtask

  task automatic chan_pulse(input logic [NR-1:0] s, input logic [NR-1:0] c, input bit honoured);
    set_ppu_reset_i = s;
    clr_ppu_reset_i = c;
    tick();
    set_ppu_reset_i = '0;
    clr_ppu_reset_i = '0;
    if (honoured) apply_chan(s, c);
  endtask

  task automatic run_check(input int d, input int cycles);
    logic [NR-1:0] s, c;
    div_i = DW'(d);
    run_i = 1'b1;
    tick();
    run_i = 1'b0;
    for (int j = 0; j <= cycles; j++) begin
      if (j > 0) begin
        s = NR'($urandom_range(0, 3));
        c = NR'($urandom_range(0, 3));
        chan_pulse(s, c, 1'b1);
      end
      chk("run_xin", 32'(xin), 32'(exp_xin(j, d)));
      chk("run_rise", 32'(xin_rise_o), 32'(exp_rise(j, d)));
      chk("run_busy", 32'(busy_o), 32'd0);
      chk("run_rst", 32'(ppu_reset_n), 32'(exp_rst));
    end
  endtask

  task automatic step_check(input int d, input int n);
    int len, rises;
    logic [NR-1:0] s, c;
    len = 2 * n * (d + 1);
    rises = 0;
    div_i = DW'(d);
    step_count_i = SW'(n);
    step_i = 1'b1;
    tick();
    step_i = 1'b0;
    for (int j = 0; j <= len + 2; j++) begin
      if (j > 0) begin
        if (j == 2) begin
          run_i = 1'b1;
          start_seq_i = 1'b1;
        end
        s = NR'($urandom_range(0, 3));
        c = NR'($urandom_range(0, 3));
        chan_pulse(s, c, 1'b1);
        run_i = 1'b0;
        start_seq_i = 1'b0;
      end
      if (xin_rise_o === 1'b1) rises++;
      chk("step_xin", 32'(xin), (j < len) ? 32'(exp_xin(j, d)) : 32'd0);
      chk("step_rise", 32'(xin_rise_o), (j < len) ? 32'(exp_rise(j, d)) : 32'd0);
      chk("step_busy", 32'(busy_o), (j < len) ? 32'd1 : 32'd0);
      chk("step_rst", 32'(ppu_reset_n), 32'(exp_rst));
    end
    chk("step_count", 32'(rises), 32'(n));
  endtask

  task automatic seq_check(input int d);
    int len;
    len = 2 * HOLD * (d + 1);
    div_i = DW'(d);
    start_seq_i = 1'b1;
    tick();
    start_seq_i = 1'b0;
    exp_rst = '0;
    for (int j = 0; j <= len + 8; j++) begin
      if (j > 0) begin
        // Channel pulses up to and including the release edge must be ignored.
        if (j <= len) begin
          chan_pulse(NR'($urandom_range(0, 3)), NR'($urandom_range(0, 3)), 1'b0);
        end else begin
          tick();
        end
      end
      if (j == len) exp_rst = '1;
      chk("seq_rst", 32'(ppu_reset_n), 32'(exp_rst));
      chk("seq_xin", 32'(xin), 32'(exp_xin(j, d)));
      chk("seq_rise", 32'(xin_rise_o), 32'(exp_rise(j, d)));
      chk("seq_busy", 32'(busy_o), (j < len) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic stop_now();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
  endtask

  initial begin
    exp_rst = '0;
    // Reset state
    tick();
    tick();
    chk("rst_xin", 32'(xin), 32'd0);
    chk("rst_n", 32'(ppu_reset_n), 32'd0);
    chk("rst_rise", 32'(xin_rise_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_edges", xin_edges_o, 32'd0);
    reset = 1'b1;
    tick();
    chk("idle_xin", 32'(xin), 32'd0);

    // Manual XIN
    xin_hi_i = 1'b1;
    tick();
    xin_hi_i = 1'b0;
    chk("man_hi_xin", 32'(xin), 32'd1);
    chk("man_hi_rise", 32'(xin_rise_o), 32'd1);
    tick();
    chk("man_rise_gone", 32'(xin_rise_o), 32'd0);
    xin_hi_i = 1'b1;
    xin_lo_i = 1'b1;
    tick();
    xin_hi_i = 1'b0;
    xin_lo_i = 1'b0;
    chk("man_both_xin", 32'(xin), 32'd1);
    xin_lo_i = 1'b1;
    tick();
    xin_lo_i = 1'b0;
    chk("man_lo_xin", 32'(xin), 32'd0);
    chk("man_lo_rise", 32'(xin_rise_o), 32'd0);

    // Reset channels in IDLE
    chan_pulse(2'b01, 2'b10, 1'b1);
    chk("chan_split", 32'(ppu_reset_n), 32'(2'b10));
    chan_pulse(2'b10, 2'b10, 1'b1);
    chk("chan_both", 32'(ppu_reset_n), 32'(exp_rst));
    for (int i = 0; i < 16; i++) begin
      chan_pulse(NR'($urandom_range(0, 3)), NR'($urandom_range(0, 3)), 1'b1);
      chk("chan_rand", 32'(ppu_reset_n), 32'(exp_rst));
    end

    // Free run, div=3, stop while high
    run_check(3, 20);
    stop_now();
    chk("stop_xin", 32'(xin), 32'd0);
    chk("stop_busy", 32'(busy_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stop_idle_xin", 32'(xin), 32'd0);
    end
    for (int r = 0; r < 3; r++) begin
      run_check(int'($urandom_range(0, 5)), int'($urandom_range(10, 40)));
      stop_now();
      chk("stop_rand_xin", 32'(xin), 32'd0);
    end

    // Single step
    step_check(0, 5);
    for (int r = 0; r < 3; r++) begin
      step_check(int'($urandom_range(0, 3)), int'($urandom_range(1, 6)));
    end
    step_count_i = '0;
    step_i = 1'b1;
    tick();
    step_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("step0_busy", 32'(busy_o), 32'd0);
      chk("step0_xin", 32'(xin), 32'd0);
      chk("step0_rise", 32'(xin_rise_o), 32'd0);
      tick();
    end

    // Hardware reset sequence
    chan_pulse(2'b00, 2'b11, 1'b1);
    seq_check(1);
    stop_now();
    seq_check(int'($urandom_range(0, 2)));
    stop_now();

    // Stop mid-sequence keeps resets asserted
    chan_pulse(2'b00, 2'b11, 1'b1);
    div_i = '0;
    start_seq_i = 1'b1;
    tick();
    start_seq_i = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    stop_now();
    chk("seqstop_rst", 32'(ppu_reset_n), 32'd0);
    chk("seqstop_xin", 32'(xin), 32'd0);
    chk("seqstop_busy", 32'(busy_o), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    chk("seqstop_hold", 32'(ppu_reset_n), 32'd0);

    // Synchronous reset mid-step
    chan_pulse(2'b00, 2'b11, 1'b1);
    div_i = DW'(2);
    step_count_i = SW'(10);
    step_i = 1'b1;
    tick();
    step_i = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    reset = 1'b0;
    tick();
    chk("midrst_xin", 32'(xin), 32'd0);
    chk("midrst_n", 32'(ppu_reset_n), 32'd0);
    chk("midrst_rise", 32'(xin_rise_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_edges", xin_edges_o, 32'd0);
    reset = 1'b1;
    exp_rst = '0;
    tick();

    // Edge counter: 300 rising edges at div=0
    div_i = '0;
    run_i = 1'b1;
    tick();
    run_i = 1'b0;
    for (int i = 0; i < 600; i++) tick();
    stop_now();
    tick();
    tick();
`ifdef PPU_XIN_EDGE_COUNTER_EN
    chk("edges_300", xin_edges_o, 32'd300);
`else
    chk("edges_off", xin_edges_o, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
